// File: rtl/ppu_pkg.sv
// ppu_pkg: shared PPU mode encoding, LCD geometry and framebuffer entry type
package ppu_pkg;

    typedef enum logic [1:0] {
        H_BLANK = 2'd0,
        V_BLANK = 2'd1,
        SCAN    = 2'd2,
        DRAW    = 2'd3
    } ppu_mode_t;

    localparam int LCD_W = 160;
    localparam int LCD_H = 144;
    localparam int FB_AW = 15;

    typedef struct packed {
        logic [FB_AW-1:0] addr;
        logic [1:0]       shade;
    } fb_entry_t;

endpackage

// File: rtl/ppu_px_fifo.sv
// ppu_px_fifo: synchronous ring FIFO with wrap-bit pointers for full/empty detection
module ppu_px_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr;
    logic [AW:0]  rd;

    assign dout  = mem[rd[AW-1:0]];
    assign empty = wr == rd;
    assign full  = wr == {~rd[AW], rd[AW-1:0]};

    // entry storage, written at the tail
    always_ff @(posedge clk) begin
        if (push)
            mem[wr[AW-1:0]] <= din;
    end

    // ring pointers; the extra top bit tells full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wr <= '0;
            rd <= '0;
        end else begin
            if (push)
                wr <= wr + (AW+1)'(1);
            if (pop)
                rd <= rd + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/ppu_fb_writer.sv
// ppu_fb_writer: palette-maps PPU pixels, buffers them and writes them to the framebuffer (PPU_FB_WRITER_DROP_CNT_EN adds drop_cnt)
module ppu_fb_writer #(
    parameter int FIFO_DEPTH = 16,
    parameter int LCD_W      = ppu_pkg::LCD_W,
    parameter int LCD_H      = ppu_pkg::LCD_H
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  ppu_mode,
    input  logic [7:0]  ly,
    input  logic [7:0]  bgp,
    input  logic [1:0]  px_in,
    input  logic        px_valid,
    output logic [14:0] fb_addr,
    output logic [1:0]  fb_data,
    output logic        fb_we,
    input  logic        fb_ready,
    output logic        overflow,
    output logic        frame_done
`ifdef PPU_FB_WRITER_DROP_CNT_EN
    ,
    output logic [15:0] drop_cnt
`endif
);

    import ppu_pkg::*;

    localparam logic [7:0]       XMAX = 8'(LCD_W);
    localparam logic [7:0]       YMAX = 8'(LCD_H);
    localparam logic [FB_AW-1:0] LAST = FB_AW'(LCD_W * LCD_H - 1);

    ppu_mode_t prev_mode;
    logic [7:0] x;
    logic [7:0] line_y;
    logic [7:0] x_e;
    logic [7:0] y_e;
    logic       draw;
    logic       draw_start;
    logic       clr;
    logic       px_draw;
    logic       push_req;
    logic       push;
    logic       pop;
    logic       load;
    logic       drop;
    logic       full;
    logic       empty;
    fb_entry_t  in_entry;
    fb_entry_t  head;

    // line sync, pixel acceptance and FIFO handshake decisions
    always_comb begin
        draw          = ppu_mode_t'(ppu_mode) == DRAW;
        draw_start    = draw && prev_mode != DRAW;
        clr           = draw_start && ly == 8'd0;
        x_e           = draw_start ? 8'd0 : x;
        y_e           = draw_start ? ly : line_y;
        px_draw       = px_valid && draw;
        push_req      = px_draw && x_e < XMAX && y_e < YMAX;
        load          = !fb_we || fb_ready;
        pop           = load && !empty;
        push          = push_req && (!full || pop);
        drop          = push_req && !push;
        in_entry.addr = {y_e, 7'd0} + {2'd0, y_e, 5'd0} + {7'd0, x_e};
        in_entry.shade = bgp[{px_in, 1'b0} +: 2];
    end

    ppu_px_fifo #(
        .DEPTH(FIFO_DEPTH),
        .W    ($bits(fb_entry_t))
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (in_entry),
        .pop  (pop),
        .dout (head),
        .full (full),
        .empty(empty)
    );

    // mode history and x/line counters; x keeps counting across drops and saturates at the line end
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_mode <= H_BLANK;
            x         <= 8'd0;
            line_y    <= 8'd0;
        end else begin
            prev_mode <= ppu_mode_t'(ppu_mode);
            line_y    <= y_e;
            x         <= px_draw ? (x_e < XMAX ? x_e + 8'd1 : XMAX) : x_e;
        end
    end

    // sticky overflow, cleared at the start of a new frame; a drop on that edge wins
    always_ff @(posedge clk) begin
        if (rst)
            overflow <= 1'b0;
        else
            overflow <= drop || (overflow && !clr);
    end

`ifdef PPU_FB_WRITER_DROP_CNT_EN
    logic [15:0] cnt_base;

    // saturating dropped-pixel counter, restarted with the overflow flag
    always_comb begin
        cnt_base = clr ? 16'd0 : drop_cnt;
    end

    // drop counter register
    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt <= 16'd0;
        else
            drop_cnt <= cnt_base + 16'(drop && cnt_base != 16'hFFFF);
    end
`endif

    // output holding register, refilled from the FIFO head whenever it is free or being vacated
    always_ff @(posedge clk) begin
        if (rst) begin
            fb_we   <= 1'b0;
            fb_addr <= 15'd0;
            fb_data <= 2'd0;
        end else if (load) begin
            fb_we <= !empty;
            if (!empty) begin
                fb_addr <= head.addr;
                fb_data <= head.shade;
            end
        end
    end

    // end-of-frame pulse after the last framebuffer address is written
    always_ff @(posedge clk) begin
        if (rst)
            frame_done <= 1'b0;
        else
            frame_done <= fb_we && fb_ready && fb_addr == LAST;
    end

endmodule

// File: tb/tb_ppu_fb_writer.sv
// tb_ppu_fb_writer: scoreboard bench for ppu_fb_writer against a pixel-level reference model
module tb_ppu_fb_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  ppu_mode = 2'd0;
    logic [7:0]  ly = 8'd0;
    logic [7:0]  bgp = 8'hE4;
    logic [1:0]  px_in = 2'd0;
    logic        px_valid = 1'b0;
    logic        fb_ready = 1'b1;
    logic [14:0] fb_addr;
    logic [1:0]  fb_data;
    logic        fb_we;
    logic        overflow;
    logic        frame_done;
`ifdef PPU_FB_WRITER_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int fd_count = 0;

    // reference model state: pending writes in order, FIFO occupancy, output slot, counters
    logic [16:0] m_q[$];
    int m_cnt = 0;
    int m_drops = 0;
    int m_x = 0;
    int m_y = 0;
    int m_prev = 0;
    bit m_slot = 0;
    bit m_ovf = 0;

    ppu_fb_writer #(.FIFO_DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .ppu_mode  (ppu_mode),
        .ly        (ly),
        .bgp       (bgp),
        .px_in     (px_in),
        .px_valid  (px_valid),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .fb_we     (fb_we),
        .fb_ready  (fb_ready),
        .overflow  (overflow),
        .frame_done(frame_done)
`ifdef PPU_FB_WRITER_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int shade_of(input int pal, input int idx);
        return (pal >> (2 * idx)) & 3;
    endfunction

    // apply the upcoming clock edge to the model, then advance the DUT past it
    task automatic step();
        bit ds, pr, load, pop, acc;
        int xe, ye;
        if (rst) begin
            m_q.delete();
            m_cnt = 0; m_slot = 0; m_ovf = 0; m_drops = 0;
            m_x = 0; m_y = 0; m_prev = 0;
        end else begin
            ds   = ppu_mode == 3 && m_prev != 3;
            xe   = ds ? 0 : m_x;
            ye   = ds ? int'(ly) : m_y;
            pr   = px_valid && ppu_mode == 3 && xe < 160 && ye < 144;
            load = !m_slot || fb_ready;
            pop  = load && m_cnt > 0;
            acc  = pr && (m_cnt < 16 || pop);
            if (ds && ly == 0) begin
                m_ovf = 0;
                m_drops = 0;
            end
            if (pr && !acc) begin
                m_ovf = 1;
                if (m_drops < 65535) m_drops++;
            end
            if (acc) m_q.push_back({15'(ye * 160 + xe), 2'(shade_of(bgp, px_in))});
            if (load) m_slot = m_cnt > 0;
            m_cnt = m_cnt + int'(acc) - int'(pop);
            if (px_valid && ppu_mode == 3) m_x = xe < 160 ? xe + 1 : 160;
            else m_x = xe;
            m_y = ye;
            m_prev = ppu_mode;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic line(input logic [7:0] y, input int n, input bit ready, input bit rnd);
        ppu_mode = 2'd2;
        px_valid = rnd ? 1'($urandom % 2) : 1'b0;
        px_in = 2'($urandom % 4);
        fb_ready = rnd ? 1'($urandom % 4 != 0) : ready;
        step();
        ppu_mode = 2'd3;
        ly = y;
        for (int i = 0; i < n; i++) begin
            px_in = rnd ? 2'($urandom % 4) : 2'(i % 4);
            px_valid = rnd ? 1'($urandom % 5 != 0) : 1'b1;
            fb_ready = rnd ? 1'($urandom % 4 != 0) : ready;
            step();
        end
        ppu_mode = 2'd0;
        px_valid = rnd ? 1'($urandom % 2) : 1'b0;
        step();
        px_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        ppu_mode = 2'd0;
        px_valid = 1'b0;
        fb_ready = 1'b1;
        while (m_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        if (m_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d writes still pending after %0d cycles", m_q.size(), n);
            m_q.delete();
        end
        step();
        step();
        chk("idle_fb_we", fb_we, 0);
    endtask

    // monitor: pops the expected write whenever the DUT hands one over, checks frame_done and stall stability
    bit exp_fd = 0;
    bit prev_stall = 0;
    logic [14:0] prev_addr;
    logic [1:0] prev_data;
    always @(negedge clk) begin
        logic [16:0] e;
        if (rst) begin
            exp_fd = 0;
            prev_stall = 0;
        end else begin
            chk("frame_done", frame_done, exp_fd);
            if (frame_done) fd_count++;
            if (prev_stall) begin
                chk("stall_fb_we", fb_we, 1);
                chk("stall_fb_addr", fb_addr, prev_addr);
                chk("stall_fb_data", fb_data, prev_data);
            end
            exp_fd = 0;
            if (fb_we && fb_ready) begin
                if (m_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data %0d with nothing pending", fb_addr, fb_data);
                end else begin
                    e = m_q.pop_front();
                    chk("fb_addr", fb_addr, e[16:2]);
                    chk("fb_data", fb_data, e[1:0]);
                    exp_fd = e[16:2] == 15'd23039;
                end
            end
            prev_stall = fb_we && !fb_ready;
            prev_addr = fb_addr;
            prev_data = fb_data;
        end
    end

    initial begin
        int f0;
        repeat (3) step();
        rst = 1'b0;
        chk("reset_fb_we", fb_we, 0);
        chk("reset_fb_addr", fb_addr, 0);
        chk("reset_fb_data", fb_data, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_frame_done", frame_done, 0);

        bgp = 8'hE4;
        line(8'd0, 160, 1'b1, 1'b0);
        drain();
        chk("line0_overflow", overflow, 0);

        bgp = 8'h1B;
        line(8'd0, 160, 1'b1, 1'b0);
        drain();

        f0 = fd_count;
        bgp = 8'hE4;
        line(8'd143, 168, 1'b1, 1'b0);
        drain();
        chk("frame_done_pulses", fd_count - f0, 1);

        line(8'd0, 40, 1'b0, 1'b0);
        chk("stall_overflow", overflow, 1);
`ifdef PPU_FB_WRITER_DROP_CNT_EN
        chk("stall_drop_cnt", drop_cnt, 23);
`endif
        drain();
        chk("held_overflow", overflow, 1);
        ppu_mode = 2'd2;
        step();
        ppu_mode = 2'd3;
        ly = 8'd0;
        step();
        ppu_mode = 2'd0;
        step();
        chk("new_frame_overflow", overflow, 0);
`ifdef PPU_FB_WRITER_DROP_CNT_EN
        chk("new_frame_drop_cnt", drop_cnt, 0);
`endif

        for (int k = 0; k < 10; k++) begin
            bgp = 8'($urandom);
            line(k % 4 == 3 ? 8'd143 : 8'($urandom_range(0, 150)), $urandom_range(80, 175), 1'b1, 1'b1);
            chk("rand_overflow", overflow, m_ovf);
`ifdef PPU_FB_WRITER_DROP_CNT_EN
            chk("rand_drop_cnt", drop_cnt, m_drops);
`endif
        end
        drain();

        ppu_mode = 2'd2;
        step();
        ppu_mode = 2'd3;
        ly = 8'd5;
        fb_ready = 1'b0;
        for (int i = 0; i < 25; i++) begin
            px_in = 2'($urandom % 4);
            px_valid = 1'b1;
            step();
        end
        chk("pre_reset_overflow", overflow, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        ppu_mode = 2'd0;
        px_valid = 1'b0;
        chk("midreset_fb_we", fb_we, 0);
        chk("midreset_overflow", overflow, 0);
        chk("midreset_frame_done", frame_done, 0);
`ifdef PPU_FB_WRITER_DROP_CNT_EN
        chk("midreset_drop_cnt", drop_cnt, 0);
`endif
        step();
        chk("post_reset_fb_we", fb_we, 0);
        line(8'd3, 20, 1'b1, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ppu_fb_writer.md
Name: ppu_fb_writer

Overview:
- Downstream consumer of the PPU pixel stream. Takes each 2-bit pixel index from the PPU shift register together with its valid strobe, maps it through the BGP palette to a shade, and tags it with its framebuffer address.
- Pixels are buffered in a small FIFO and written into the 160x144 2-bit framebuffer RAM over a valid/ready write port.
- Decouples PPU pixel timing from framebuffer port arbitration; the video scan-out block reads that framebuffer.

Parameters:
- FIFO_DEPTH, 16, number of pending pixel entries; power of two, minimum 2.
- LCD_W, 160, visible pixels per line.
- LCD_H, 144, visible lines per frame.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- ppu_mode  in  2  PPU mode; encoding from shared package: H_BLANK=0, V_BLANK=1, SCAN=2, DRAW=3.
- ly  in  8  current PPU scanline.
- bgp  in  8  BG palette register (FF47).
- px_in  in  2  pixel colour index from the PPU.
- px_valid  in  1  px_in is valid this cycle.
- fb_addr  out  15  framebuffer address, y*160+x.
- fb_data  out  2  shade, 0 = white … 3 = black.
- fb_we  out  1  write request (valid).
- fb_ready  in  1  framebuffer accepts the write on this edge.
- overflow  out  1  sticky: at least one pixel was dropped because the FIFO was full.
- frame_done  out  1  one-cycle pulse when the last pixel of line 143 is accepted by the framebuffer.

Behaviour:
- Reset: fb_we=0, fb_addr=0, fb_data=0, overflow=0, frame_done=0; FIFO empty; x=0, y=0.
- Reset mid-operation discards all pending FIFO entries and any held write.
- Line sync: on the first cycle ppu_mode==DRAW after a non-DRAW cycle (registered previous mode), set x<=0 and line_y<=ly.
  - If ly==0 on that edge, clear overflow (new frame).
- Palette map is combinational: shade = bgp[2*px_in+1 : 2*px_in].
- Pixel acceptance, on a clock edge with px_valid=1 and ppu_mode==DRAW:
  - If x<LCD_W and line_y<LCD_H: push {line_y*160+x, shade} into the FIFO; x<=x+1.
  - If x>=LCD_W: the pixel is clipped. It is not pushed, not counted as overflow, and x saturates at LCD_W.
  - If line_y>=LCD_H: the pixel is discarded.
  - px_valid outside DRAW is ignored.
- Address arithmetic: 15-bit; line_y*160 computed as (line_y<<7)+(line_y<<5); maximum value 23039.
- FIFO full:
  - A push is accepted if the FIFO is not full, or if a pop happens on the same edge.
  - Otherwise the pixel is dropped, overflow<=1, and x still increments so later pixels keep correct addresses.
  - Simultaneous push and pop on an empty FIFO behaves as a push followed by a pop ordering; no bypass.
- Output stage: one holding register (fb_we/fb_addr/fb_data).
  - Loaded from the FIFO head when the slot is empty, or being vacated this edge (fb_we & fb_ready).
  - While fb_we=1 and fb_ready=0, fb_addr and fb_data hold stable.
  - fb_we drops the edge after acceptance if the FIFO is empty.
- Latency: px_valid sampled at edge N → fb_we=1 after edge N+1 (FIFO previously empty, slot free).
  - Full throughput: 1 pixel/cycle with fb_ready held high.
- frame_done: asserted for the cycle after the edge where an entry with address 23039 is accepted.

Optional Feature:
- Macro: PPU_FB_WRITER_DROP_CNT_EN.
- When defined: extra output drop_cnt (16 bits).
  - Increments on every overflow drop; saturates at 16'hFFFF.
  - Cleared with overflow (ly==0 DRAW entry) and on reset.
- When undefined: the port and its counter are absent; overflow-flag behaviour is unchanged.

Decomposition:
- Shared package ppu_pkg holds:
  - the PPU mode enum (H_BLANK, V_BLANK, SCAN, DRAW);
  - constants LCD_W, LCD_H, FB_AW=15;
  - the 17-bit fb entry struct {addr, shade}.
- One sub-module, ppu_px_fifo: synchronous FIFO, parameterised depth and width, with push/pop/full/empty. Ring pointers carry an extra wrap bit.

Test Plan:
- Reset then one DRAW line with ly=0, bgp=8'hE4, 160 pixels px_in=0,1,2,3 repeating, fb_ready=1 → 160 writes, addresses 0..159, data 0,1,2,3 repeating, no gaps after the first; overflow=0.
- Same line with bgp=8'h1B → data 3,2,1,0 repeating.
- ly=143, 168 pixels fed → addresses 22880..23039 only (8 clipped); one frame_done pulse after address 23039 is accepted.
- fb_ready=0 for 40 cycles while 40 pixels arrive (FIFO_DEPTH=16) → 17 entries retained (16 FIFO + 1 held), overflow=1; after release the next writes are addresses 0..16, then address 40 onward; fb_addr stable while stalled.
- Stall, then rst asserted mid-stream → fb_we=0 the next cycle; FIFO empty; overflow=0; the next line starts at x=0.
- With PPU_FB_WRITER_DROP_CNT_EN: repeat the overflow scenario → drop_cnt=23; a new frame with ly=0 DRAW entry → drop_cnt=0 and overflow=0.
